// File: rtl/ql_preio_a2f_tx.sv
// ql_preio_a2f_tx -- SoC-side serial transmitter for the A2F input of a QL_PREIO pad.
//
// Takes parallel words over a valid/ready handshake and sends each one as a frame:
// a start bit (0), the payload LSB first, an optional even-parity bit, then
// STOP_BITS stop bits (1). Every bit is held on the pad for CLK_DIV clock cycles.
// The idle line level is 1.
//
// Optional feature: define QL_PREIO_A2F_TX_PARITY_EN to add one even-parity bit
// (the XOR of the payload) after the data bits. The default build has no parity.
//
// Reset is synchronous and active-high.

module ql_preio_a2f_tx #(
  parameter int DATA_WIDTH = 8,     // payload bits per frame, 1..16
  parameter int CLK_DIV    = 4,     // clock cycles per bit period, 1..65535
  parameter int STOP_BITS  = 1      // stop bits per frame, 1 or 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [0:0]            gfpga_pad_QL_PREIO_A2F,
  output logic                  tx_busy,
  output logic [15:0]           tx_frames
);

  // Frame phases. The encodings are fixed so the parity state can be compiled
  // out without renumbering the others.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef QL_PREIO_A2F_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  // Terminal values of the bit timer, the data bit index and the stop bit index.
  localparam int               IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [15:0]      DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;        // cycles elapsed in the current bit
  logic [IDX_W-1:0]        bit_q, bit_d;        // data bit being sent
  logic                    stop_q, stop_d;      // stop bit being sent
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;    // payload, bit 0 is on the line
  logic                    line_q, line_d;      // registered pad level
  logic                    ready_q, ready_d;
  logic [15:0]             frames_q, frames_d;
`ifdef QL_PREIO_A2F_TX_PARITY_EN
  logic                    parity_q, parity_d;  // even parity of the accepted payload
`endif

  logic accept;
  logic bit_end;

  assign accept  = tx_valid && ready_q;
  assign bit_end = (cnt_q == DIV_LAST);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register in the design samples the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each phase ends on the terminal count of the bit timer.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_q == BIT_LAST)) begin
`ifdef QL_PREIO_A2F_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef QL_PREIO_A2F_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end && (stop_q == STOP_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: bit timer, bit indices and the payload shifter.
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
`ifdef QL_PREIO_A2F_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == S_IDLE) begin
      cnt_d  = '0;
      bit_d  = '0;
      stop_d = 1'b0;
      if (accept) begin
        shift_d  = tx_data;
`ifdef QL_PREIO_A2F_TX_PARITY_EN
        parity_d = ^tx_data;
`endif
      end
    end else if (bit_end) begin
      cnt_d = '0;
      if (state_q == S_DATA) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
      end
      if (state_q == S_STOP) begin
        stop_d = stop_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Output logic: the line level, ready and frame count the registers take next.
  // Deriving the line from the next state keeps it registered and glitch-free:
  // it can only change on the edge where a bit period ends.
  always_comb begin
    line_d = 1'b1;
    unique case (state_d)
      S_IDLE:   line_d = 1'b1;
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
`ifdef QL_PREIO_A2F_TX_PARITY_EN
      S_PARITY: line_d = parity_q;
`endif
      S_STOP:   line_d = 1'b1;
      default:  line_d = 1'b1;
    endcase

    // Ready drops on the accepting edge and returns on the edge that ends the
    // last stop bit; out of reset it rises on the first edge without reset.
    ready_d = (state_d == S_IDLE);

    frames_d = frames_q;
    if ((state_q == S_STOP) && (state_d == S_IDLE)) begin
      frames_d = frames_q + 16'd1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      line_q   <= 1'b1;
      ready_q  <= 1'b0;
      frames_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      line_q   <= line_d;
      ready_q  <= ready_d;
      frames_q <= frames_d;
    end
  end

  // Payload registers.
  // NOTE: these carry no reset; they are loaded on every acceptance before any
  // of their bits reach the line, so their power-up contents are never seen.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
`ifdef QL_PREIO_A2F_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign tx_ready               = ready_q;
  assign gfpga_pad_QL_PREIO_A2F = line_q;
  assign tx_busy                = (state_q != S_IDLE);
  assign tx_frames              = frames_q;

endmodule

// File: tb/tb_ql_preio_a2f_tx.sv
// Testbench for ql_preio_a2f_tx.
// Two instances: dut_a with the defaults (8 data bits, 4 cycles per bit, 1 stop bit)
// and dut_b with 1 data bit, 1 cycle per bit and 2 stop bits. Each send pushes the
// hand-computed frame (bit k of the vector is frame bit k, start bit first) onto a
// scoreboard queue; a per-instance monitor watches the pad, pops an entry on every
// start bit and compares timing, bit values, busy, ready and the frame count.

`timescale 1ns/1ps

module tb_ql_preio_a2f_tx;

`ifdef QL_PREIO_A2F_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // (1 start + 8 data + parity + 1 stop) * 4 cycles
  localparam int FRAME_CYC_A = (PAR != 0) ? 44 : 40;

  typedef struct {
    int          id;      // which instance
    int          start;   // cycle whose negedge first shows the start bit
    logic [31:0] bits;    // expected frame, bit 0 = start bit
    int          nbits;
    int          trunc;   // nonzero: frame cut by reset after this many cycles
    logic [15:0] cnt;     // tx_frames expected once the frame completes
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mon_en;
  logic [15:0] data_w   [2];
  logic        valid_w  [2];
  logic        ready_w  [2];
  logic        busy_w   [2];
  logic        line_w   [2];
  logic [15:0] frames_w [2];
  logic [0:0]  pad_a, pad_b;
  logic [15:0] exp_frames [2];

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ql_preio_a2f_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .STOP_BITS(1)) dut_a (
    .clk                    (clk),
    .reset                  (reset),
    .tx_data                (data_w[0][7:0]),
    .tx_valid               (valid_w[0]),
    .tx_ready               (ready_w[0]),
    .gfpga_pad_QL_PREIO_A2F (pad_a),
    .tx_busy                (busy_w[0]),
    .tx_frames              (frames_w[0])
  );

  ql_preio_a2f_tx #(.DATA_WIDTH(1), .CLK_DIV(1), .STOP_BITS(2)) dut_b (
    .clk                    (clk),
    .reset                  (reset),
    .tx_data                (data_w[1][0:0]),
    .tx_valid               (valid_w[1]),
    .tx_ready               (ready_w[1]),
    .gfpga_pad_QL_PREIO_A2F (pad_b),
    .tx_busy                (busy_w[1]),
    .tx_frames              (frames_w[1])
  );

  assign line_w[0] = pad_a[0];
  assign line_w[1] = pad_b[0];

  function automatic int div_of(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  function automatic int nbits_of(input int id);
    return (id == 0) ? (1 + 8 + PAR + 1) : (1 + 1 + PAR + 2);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called at a negedge. Offers the word, waits for ready, and pushes the expected
  // frame; returns at the negedge where the start bit is first visible.
  task automatic send(input int id, input logic [15:0] d, input logic [31:0] bits,
                      input int trunc, input bit hold, output int start);
    exp_t e;
    int   waited = 0;
    valid_w[id] = 1'b1;
    data_w[id]  = d;
    while (ready_w[id] !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) begin
      check("send_ready_timeout", 32'(ready_w[id]), 32'd1);
      valid_w[id] = 1'b0;
      start = -1;
      return;
    end
    start = cyc + 1;
    if (trunc == 0) exp_frames[id] = exp_frames[id] + 16'd1;
    e.id    = id;
    e.start = start;
    e.bits  = bits;
    e.nbits = nbits_of(id);
    e.trunc = trunc;
    e.cnt   = exp_frames[id];
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) valid_w[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (60) @(negedge clk);
  endtask

  task automatic monitor(input int id);
    exp_t        e;
    int          div, total, glitch, busy_bad, n_samp;
    logic [31:0] obs, mask;
    logic        first;
    forever begin
      @(negedge clk);
      if (mon_en === 1'b1 && line_w[id] === 1'b0) begin
        if (sb_q.size() == 0 || sb_q[0].id != id) begin
          check($sformatf("unexpected_start_dut%0d", id), 32'(line_w[id]), 32'd1);
          continue;
        end
        e = sb_q.pop_front();
        check("start_cycle", 32'(cyc), 32'(e.start));
        div      = div_of(id);
        total    = (e.trunc != 0) ? e.trunc : e.nbits * div;
        obs      = '0;
        glitch   = 0;
        busy_bad = 0;
        first    = 1'b0;
        for (int c = 0; c < total; c++) begin
          if (c > 0) @(negedge clk);
          if (c % div == 0) begin
            obs[c / div] = line_w[id];
            first        = line_w[id];
          end else if (line_w[id] !== first) begin
            glitch++;
          end
          if (busy_w[id] !== 1'b1) busy_bad++;
        end
        n_samp = (total + div - 1) / div;
        mask   = (n_samp >= 32) ? '1 : ((32'h1 << n_samp) - 32'h1);
        check("frame_bits", obs, e.bits & mask);
        check("bit_glitches", 32'(glitch), 32'd0);
        check("busy_in_frame", 32'(busy_bad), 32'd0);
        @(negedge clk);
        check("line_after", 32'(line_w[id]), 32'd1);
        check("busy_after", 32'(busy_w[id]), 32'd0);
        if (e.trunc != 0) begin
          check("ready_after_reset", 32'(ready_w[id]), 32'd0);
          check("frames_after_reset", 32'(frames_w[id]), 32'd0);
        end else begin
          check("ready_after_frame", 32'(ready_w[id]), 32'd1);
          check("frames_after_frame", 32'(frames_w[id]), 32'(e.cnt));
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s1, s2;
    reset         = 1'b1;
    mon_en        = 1'b0;
    valid_w[0]    = 1'b1;
    valid_w[1]    = 1'b1;
    data_w[0]     = 16'h00A5;
    data_w[1]     = 16'h0001;
    exp_frames[0] = '0;
    exp_frames[1] = '0;

    // Reset held 3 cycles with tx_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mon_en = 1'b1;
      check("rst_line",   32'(line_w[0]),   32'd1);
      check("rst_ready",  32'(ready_w[0]),  32'd0);
      check("rst_busy",   32'(busy_w[0]),   32'd0);
      check("rst_frames", 32'(frames_w[0]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release_a", 32'(ready_w[0]), 32'd1);
    check("ready_after_release_b", 32'(ready_w[1]), 32'd1);
    check("line_after_release",    32'(line_w[0]),  32'd1);
    valid_w[0] = 1'b0;
    valid_w[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Mid-frame reset during data bit 3 (frame cycles 16..19); reset seen at cycle 18.
    send(0, 16'h00A5, (PAR != 0) ? 32'h54A : 32'h34A, 18, 1'b0, s);
    while (cyc < s + 17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    exp_frames[0] = '0;
    exp_frames[1] = '0;
    repeat (50) @(negedge clk);
    check("frames_still_zero", 32'(frames_w[0]), 32'd0);

    // Intact frame after the abandoned one.
    send(0, 16'h003C, (PAR != 0) ? 32'h478 : 32'h278, 0, 1'b0, s);
    // 0xA5: parity 0; 0x01: parity 1.
    send(0, 16'h00A5, (PAR != 0) ? 32'h54A : 32'h34A, 0, 1'b0, s);
    send(0, 16'h0001, (PAR != 0) ? 32'h602 : 32'h202, 0, 1'b0, s);

    // Back-to-back with tx_valid held high.
    send(0, 16'h0000, (PAR != 0) ? 32'h400 : 32'h200, 0, 1'b1, s1);
    send(0, 16'h00FF, (PAR != 0) ? 32'h5FE : 32'h3FE, 0, 1'b0, s2);
    check("b2b_start_gap", 32'(s2 - s1), 32'(FRAME_CYC_A + 1));
    wait_idle();

    // Counter wrap: preload 0xFFFF, next frame completes at 0x0000.
    force dut_a.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.frames_q;
    @(negedge clk);
    exp_frames[0] = 16'hFFFF;
    check("frames_preload", 32'(frames_w[0]), 32'h0000FFFF);
    send(0, 16'h00A5, (PAR != 0) ? 32'h54A : 32'h34A, 0, 1'b0, s);
    send(0, 16'h0001, (PAR != 0) ? 32'h602 : 32'h202, 0, 1'b0, s);
    wait_idle();

    // 1 data bit, 1 cycle per bit, 2 stop bits: sending 1 gives 0,1,1,1.
    send(1, 16'h0001, (PAR != 0) ? 32'h1E : 32'hE, 0, 1'b0, s);
    send(1, 16'h0000, (PAR != 0) ? 32'h18 : 32'hC, 0, 1'b0, s);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
